// File: rtl/fact_decode.sv
`default_nettype none
// ============================================================================
// Module  : fact_decode
// Purpose : Recovers n from a 2*n! (mod 2^DATA_W) code word by a running-
//           factorial search, one multiply per SCAN cycle.
// Option  : FACT_DECODE_WRAP_MATCH_EN - scan to MAX_N and match truncated words.
// Revision: 1.0
// ============================================================================
module fact_decode #(
  parameter int DATA_W  = 32,
  parameter int MAX_N   = 15,
  parameter int K_EXACT = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        n_out,
  output logic              match,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifdef FACT_DECODE_WRAP_MATCH_EN
  localparam logic [3:0] SCAN_LIMIT = 4'(MAX_N);
`else
  localparam logic [3:0] SCAN_LIMIT = 4'(K_EXACT);
`endif

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] v_q, v_d;
  logic [DATA_W-1:0] p_q, p_d;
  logic [3:0]        k_q, k_d;
  logic [3:0]        n_q, n_d;
  logic              match_q, match_d;

  logic [4:0]        k_inc;
  logic [DATA_W-1:0] prod;
  logic              hit;
  logic              over;
  logic              at_limit;

  assign k_inc = {1'b0, k_q} + 5'd1;
  // Multiplier operand is only 5 bits wide; upper bits are constant zero.
  assign prod  = p_q * {{(DATA_W-5){1'b0}}, k_inc};

`ifdef FACT_DECODE_WRAP_MATCH_EN
  assign hit  = ({p_q[DATA_W-2:0], 1'b0} == v_q);
  assign over = 1'b0;
`else
  logic [DATA_W:0] two_p;
  assign two_p = {p_q, 1'b0};
  assign hit   = (two_p == {1'b0, v_q});
  assign over  = (two_p >  {1'b0, v_q});
`endif

  assign at_limit = (k_q == SCAN_LIMIT);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    p_d     = p_q;
    k_d     = k_q;
    n_d     = n_q;
    match_d = match_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          v_d = in_data;
          if (in_data == '0) begin
            n_d     = 4'd0;
            match_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            k_d     = 4'd1;
            p_d     = DATA_W'(1);
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (hit) begin
          n_d     = k_q;
          match_d = 1'b1;
          state_d = ST_DONE;
        end else if (over || at_limit) begin
          n_d     = 4'd0;
          match_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          k_d = k_inc[3:0];
          p_d = prod;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      p_q     <= '0;
      k_q     <= 4'd0;
      n_q     <= 4'd0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      p_q     <= p_d;
      k_q     <= k_d;
      n_q     <= n_d;
      match_q <= match_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SCAN);
  assign n_out     = n_q;
  assign match     = match_q;

endmodule
`default_nettype wire

// File: doc/fact_decode.md
Name: fact_decode

Overview:
- Inverse of the factorial encoder block. The encoder produces result = 2·n! truncated to 32 bits for a 4-bit n.
- This block accepts such a 32-bit code word and recovers n by iterative search: one multiply per cycle over a running factorial.
- It reports n and a match flag through valid/ready handshakes on both sides.
- It sits downstream of the encoder in loopback and self-check paths.

Parameters:
- DATA_W, 32: code word width. The running product is also DATA_W bits, truncated mod 2^DATA_W.
- MAX_N, 15: highest k scanned in wrap mode. Equals the largest value of the 4-bit n_out.
- K_EXACT, 12: largest k with 2·k! < 2^DATA_W. This is the scan limit in non-wrap mode and must be consistent with DATA_W.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  code word present on in_data
- in_ready  output  1  block can accept a code word
- in_data  input  DATA_W  code word, 2·n! mod 2^DATA_W
- out_valid  output  1  result present on n_out/match
- out_ready  input  1  consumer accepts the result
- n_out  output  4  decoded n; 0 when match=0
- match  output  1  1 = in_data is a valid code word; 0 = no n decodes to it
- busy  output  1  high in SCAN state

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; in_ready=1; out_valid=0, n_out=0, match=0, busy=0. Internal value, k and p are cleared. Reset overrides every state, including mid-SCAN and mid-DONE; the in-flight word is discarded with no output.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch v=in_data.
  - If v==0, go to DONE with n_out=0, match=1. This mirrors the encoder's 0! coding as 0.
  - Otherwise set k=1, p=1 and go to SCAN.
- State SCAN (in_ready=0, busy=1). Each cycle, evaluate in priority order:
  1. If 2·p == v: go to DONE with n_out=k, match=1.
  2. Else if non-wrap mode and 2·p > v (compare at DATA_W+1 bits): go to DONE with n_out=0, match=0 (early exit).
  3. Else if k == scan limit (K_EXACT non-wrap, MAX_N wrap): go to DONE with n_out=0, match=0.
  4. Else: k <= k+1 and p <= (p·(k+1)) mod 2^DATA_W.
- SCAN cycle counts: a match at k costs exactly k SCAN cycles; v==0 costs 0 SCAN cycles.
- State DONE:
  - out_valid=1; n_out and match stay stable until out_ready=1.
  - On out_valid&out_ready: go to IDLE and clear out_valid. n_out and match may keep their values.
  - out_ready held low stalls indefinitely; in_ready stays 0, so there is no input overrun.
- Throughput: one word in flight; no new word is accepted until the result handshake completes.
- The first match in ascending k wins.
- Multiplier: DATA_W×5 product truncated to DATA_W bits. Only one multiply per cycle is permitted.

Optional Feature:
- Macro: FACT_DECODE_WRAP_MATCH_EN.
- Defined:
  - Scan continues to k=MAX_N.
  - Comparison uses the low DATA_W bits of 2·p, so truncated code words for n=13..15 decode.
  - Step 2 (early exit) is removed.
- Undefined:
  - Scan limit is K_EXACT with early exit on 2·p > v.
  - Words that are valid only in truncated form report match=0.

Test Plan:
- in_data=0 → out_valid after 0 SCAN cycles; n_out=0, match=1.
- in_data=2 → 1 SCAN cycle; n_out=1, match=1. in_data=12 → 3 SCAN cycles; n_out=3, match=1.
- in_data=958003200 → 12 SCAN cycles; n_out=12, match=1.
- in_data=5, macro undefined → early exit after 3 SCAN cycles (2, 4, 12>5); n_out=0, match=0.
- in_data=3864107008 (2·13! mod 2^32):
  - macro defined → n_out=13, match=1 after 13 SCAN cycles.
  - undefined → match=0 after 12 SCAN cycles.
- Hold out_ready=0 for 10 cycles in DONE with in_valid=1 → outputs stable, in_ready=0. Assert reset=0 during SCAN → next cycle IDLE, out_valid=0, in_ready=1.
